// File: rtl/updown_count_decoder.sv
// rtl/updown_count_decoder.sv - decodes 2-bit up/down counter transitions into steps, position and faults
module updown_count_decoder #(
  parameter int POS_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       cnt_in,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             locked,
  output logic             err,
  output logic [3:0]       err_cnt,
  output logic             fault
);

  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

  state_t     state;
  logic [1:0] prev;
  logic [3:0] consec;
  logic [1:0] delta;

  // Modulo-4 distance from the previous sample; 2 means a skipped count.
  assign delta = cnt_in - prev;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= ACQUIRE;
      prev    <= 2'd0;
      consec  <= 4'd0;
      step    <= 1'b0;
      dir     <= 1'b1;
      pos     <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= 4'd0;
      fault   <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (en) begin
        case (state)
          ACQUIRE: begin
            prev   <= cnt_in;
            state  <= TRACK;
            locked <= 1'b1;
          end
          TRACK: begin
            prev <= cnt_in;
            case (delta)
              2'd1: begin
                step   <= 1'b1;
                dir    <= 1'b1;
                pos    <= pos + 1'b1;
                consec <= 4'd0;
              end
              2'd3: begin
                step   <= 1'b1;
                dir    <= 1'b0;
                pos    <= pos - 1'b1;
                consec <= 4'd0;
              end
              2'd2: begin
                err    <= 1'b1;
                consec <= consec + 4'd1;
                if (err_cnt != 4'd15) err_cnt <= err_cnt + 4'd1;
                if (consec + 4'd1 == 4'(ERR_LIMIT)) begin
                  state  <= FAULT;
                  locked <= 1'b0;
                  fault  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          FAULT:   ;
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_count_decoder.sv
// tb/tb_updown_count_decoder.sv - directed self-checking bench for updown_count_decoder
module tb_updown_count_decoder;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] cnt_in;
  logic       step, dir, locked, err, fault;
  logic [7:0] pos;
  logic [3:0] err_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_count_decoder #(.POS_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cnt_in(cnt_in),
    .step(step), .dir(dir), .pos(pos), .locked(locked),
    .err(err), .err_cnt(err_cnt), .fault(fault)
  );

  task automatic cyc(input logic r, input logic e, input logic c, input logic [1:0] v);
    rst = r; en = e; clr = c; cnt_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; cnt_in = 2'd0;
    #1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_pos", pos, 0);
    chk("rst_dir", dir, 1);
    chk("rst_locked", locked, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_fault", fault, 0);

    // acquire then four up steps
    cyc(0, 1, 0, 0);
    chk("acq_step", step, 0);
    chk("acq_locked", locked, 1);
    cyc(0, 1, 0, 1);
    chk("up1_step", step, 1);
    chk("up1_pos", pos, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 0);
    chk("up4_pos", pos, 4);
    chk("up4_dir", dir, 1);
    chk("up4_errcnt", err_cnt, 0);
    chk("up4_locked", locked, 1);

    // three down steps then a hold
    cyc(0, 1, 0, 3);
    chk("dn1_step", step, 1);
    chk("dn1_dir", dir, 0);
    chk("dn1_pos", pos, 3);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 1);
    chk("dn3_pos", pos, 1);
    cyc(0, 1, 0, 1);
    chk("hold_step", step, 0);
    chk("hold_pos", pos, 1);

    // wrap: down to 0, 256 up steps, then one down
    cyc(0, 1, 0, 0);
    chk("to0_pos", pos, 0);
    for (int i = 0; i < 256; i++) cyc(0, 1, 0, 2'((i + 1) % 4));
    chk("wrap_pos", pos, 0);
    chk("wrap_step", step, 1);
    cyc(0, 1, 0, 3);
    chk("under_pos", pos, 8'hFF);
    chk("under_dir", dir, 0);
    cyc(0, 1, 0, 0);
    chk("back0_pos", pos, 0);

    // three consecutive skips -> FAULT
    cyc(0, 1, 0, 2);
    chk("e1_err", err, 1);
    chk("e1_errcnt", err_cnt, 1);
    chk("e1_fault", fault, 0);
    chk("e1_pos", pos, 0);
    cyc(0, 1, 0, 0);
    chk("e2_err", err, 1);
    chk("e2_errcnt", err_cnt, 2);
    chk("e2_locked", locked, 1);
    cyc(0, 1, 0, 2);
    chk("e3_err", err, 1);
    chk("e3_errcnt", err_cnt, 3);
    chk("e3_fault", fault, 1);
    chk("e3_locked", locked, 0);
    chk("e3_pos", pos, 0);
    chk("e3_dir", dir, 1);
    cyc(0, 1, 0, 3);
    chk("flt_step", step, 0);
    chk("flt_err", err, 0);
    chk("flt_pos", pos, 0);
    chk("flt_fault", fault, 1);
    chk("flt_errcnt", err_cnt, 3);

    // clr out of FAULT, then re-acquire without a step
    cyc(0, 1, 1, 2);
    chk("clr_fault", fault, 0);
    chk("clr_errcnt", err_cnt, 0);
    chk("clr_locked", locked, 0);
    chk("clr_pos", pos, 0);
    cyc(0, 1, 0, 1);
    chk("reacq_step", step, 0);
    chk("reacq_locked", locked, 1);

    // errors interleaved with legal steps never reach FAULT
    cyc(0, 1, 0, 3);
    chk("mix_e1", err, 1);
    cyc(0, 1, 0, 0);
    chk("mix_s1", step, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 0);
    chk("mix_errcnt", err_cnt, 3);
    chk("mix_fault2", fault, 0);
    cyc(0, 1, 0, 1);
    chk("mix_pos", pos, 2);
    cyc(0, 1, 0, 3);
    chk("mix_err4", err, 1);
    chk("mix_errcnt4", err_cnt, 4);
    chk("mix_nofault", fault, 0);
    chk("mix_locked", locked, 1);
    cyc(0, 1, 0, 0);
    chk("mix_pos3", pos, 3);

    // en low while cnt_in toggles: nothing changes, prev held
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, (i % 2 == 0) ? 2'd2 : 2'd1);
      chk("idle_step", step, 0);
      chk("idle_err", err, 0);
    end
    chk("idle_pos", pos, 3);
    cyc(0, 1, 0, 1);
    chk("resume_step", step, 1);
    chk("resume_pos", pos, 4);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 0);
    chk("pre_rst_pos", pos, 7);

    // reset mid-TRACK, then first sample re-acquires
    cyc(1, 1, 0, 1);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_errcnt", err_cnt, 0);
    cyc(0, 1, 0, 2);
    chk("post_rst_step", step, 0);
    chk("post_rst_locked", locked, 1);
    cyc(0, 1, 0, 3);
    chk("post_rst_pos", pos, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
